inv_sub_bytes_seq: RTL and testbench

Sequential InvSubBytes stage for the AES decryption datapath. It accepts a 128-bit state over a valid/ready handshake and passes it through BYTES_PER_CYCLE instances of inv_s_box, processing a group of bytes each cycle. It then presents the substituted state to the downstream inverse ShiftRows / AddRoundKey stage over a second valid/ready handshake. It trades latency for area against a fully parallel 16-box implementation.

---
 rtl/inv_sub_bytes_seq_if.sv | 23 ++
 rtl/inv_sub_bytes_seq.sv | 128 ++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the sequential InvSubBytes stage.
//   inValid/inReady/inState    : upstream state transfer (128-bit, byte 0 in MSBs)
//   outValid/outReady/outState : downstream substituted state transfer
// slave  : the InvSubBytes block's view
// master : the surrounding datapath's view (source of inputs, sink of outputs)
interface inv_sub_bytes_seq_if;
  logic         inValid;
  logic         inReady;
  logic [127:0] inState;
  logic         outValid;
  logic         outReady;
  logic [127:0] outState;

  modport slave (
    input  inValid, inState, outReady,
    output inReady, outValid, outState
  );

  modport master (
    output inValid, inState, outReady,
    input  inReady, outValid, outState
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes stage for the AES decryption datapath.
// A captured 128-bit state is pushed through BYTES_PER_CYCLE inverse S-boxes,
// one group of bytes per cycle, then held for the downstream stage.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : inv_sub_bytes_seq_if.slave (in/out valid-ready handshakes + states)
//   busy   : high while substituting or holding a result
module inv_sub_bytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic               clock,
  input  logic               reset,
  inv_sub_bytes_seq_if.slave bus,
  output logic               busy
);
  localparam int unsigned NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NUM_STEPS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SUBST = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [15:0][7:0] workReg;
  logic [15:0][7:0] nextWork;
  logic [CW-1:0]    stepCount;
  logic             outValidReg;
  logic [127:0]     outStateReg;
  logic [7:0]       laneIn  [BYTES_PER_CYCLE];
  logic [7:0]       laneOut [BYTES_PER_CYCLE];

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] bb;
    p  = '0;
    x  = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8).
  function automatic logic [7:0] invSBox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gfInv(b);
  endfunction

  // Byte n of the state lives in workReg[15-n]; group k covers bytes
  // k*B .. k*B+B-1, so lane g reads packed index 15 - (k*B + g).
  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : gLane
    logic [3:0] laneIdx;
    assign laneIdx    = 4'(15 - (32'(stepCount) * BYTES_PER_CYCLE + g));
    assign laneIn[g]  = workReg[laneIdx];
    assign laneOut[g] = invSBox(laneIn[g]);
  end

  // Write-back decoded per byte position so every select is constant.
  for (genvar p = 0; p < 16; p++) begin : gByte
    localparam int unsigned BYTE_NUM = 15 - p;
    assign nextWork[p] = (stepCount == CW'(BYTE_NUM / BYTES_PER_CYCLE))
                         ? laneOut[BYTE_NUM % BYTES_PER_CYCLE]
                         : workReg[p];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      workReg     <= '0;
      stepCount   <= '0;
      outValidReg <= 1'b0;
      outStateReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inValid) begin
            workReg   <= bus.inState;
            stepCount <= '0;
            state     <= SUBST;
          end
        end
        SUBST: begin
          workReg <= nextWork;
          if (stepCount == LAST_STEP) begin
            state       <= HOLD;
            outValidReg <= 1'b1;
            outStateReg <= nextWork;
          end else begin
            stepCount <= stepCount + 1'b1;
          end
        end
        HOLD: begin
          if (bus.outReady) begin
            outValidReg <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady  = (state == IDLE);
  assign bus.outValid = outValidReg;
  assign bus.outState = outStateReg;
  assign busy         = (state == SUBST) || (state == HOLD);
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;
  localparam logic [127:0] V1 = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] R1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V2 = 128'h50cd4a00_50cd4a00_50cd4a00_50cd4a00;
  localparam logic [127:0] R2 = 128'h6c805c52_6c805c52_6c805c52_6c805c52;

  // AES inverse S-box, one 16-byte row per high nibble.
  localparam logic [127:0] INV_ROWS [16] = '{
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic inValid = 1'b0;
  logic outReady = 1'b1;
  logic [127:0] inState = '0;
  int sel = 0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int acceptEdge = 0;
  int hsEdge = 0;
  logic [127:0] expQ [$];

  logic busy4, busy1, busy16;
  logic curInReady, curOutValid, curBusy;
  logic [127:0] curOutState;

  inv_sub_bytes_seq_if bus4 ();
  inv_sub_bytes_seq_if bus1 ();
  inv_sub_bytes_seq_if bus16 ();

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4),  .busy(busy4));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1))  dut1  (.clock(clock), .reset(reset), .bus(bus1),  .busy(busy1));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16), .busy(busy16));

  assign bus4.inValid   = inValid && (sel == 0);
  assign bus1.inValid   = inValid && (sel == 1);
  assign bus16.inValid  = inValid && (sel == 2);
  assign bus4.outReady  = outReady && (sel == 0);
  assign bus1.outReady  = outReady && (sel == 1);
  assign bus16.outReady = outReady && (sel == 2);
  assign bus4.inState   = inState;
  assign bus1.inState   = inState;
  assign bus16.inState  = inState;

  assign curInReady  = (sel == 0) ? bus4.inReady  : (sel == 1) ? bus1.inReady  : bus16.inReady;
  assign curOutValid = (sel == 0) ? bus4.outValid : (sel == 1) ? bus1.outValid : bus16.outValid;
  assign curOutState = (sel == 0) ? bus4.outState : (sel == 1) ? bus1.outState : bus16.outState;
  assign curBusy     = (sel == 0) ? busy4 : (sel == 1) ? busy1 : busy16;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] invByte(input logic [7:0] b);
    logic [127:0] r;
    r = INV_ROWS[b[7:4]] << (8 * b[3:0]);
    return r[127:120];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] src;
    logic [127:0] res;
    src = s;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      res = {res[119:0], invByte(src[127:120])};
      src = src << 8;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clock) begin
    if (reset && inValid && curInReady) begin
      expQ.push_back(model(inState));
      acceptEdge = cyc + 1;
    end
    if (reset && curOutValid && outReady) begin
      if (expQ.size() == 0) check("unexpectedOut", 128'(curOutValid), 128'(0));
      else check("outState", curOutState, expQ.pop_front());
      hsEdge = cyc + 1;
    end
  end

  task automatic waitOutValid(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (curOutValid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) check("outValidTimeout", 128'(0), 128'(1));
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(negedge clock);
    check("drained", 128'(expQ.size()), 128'(0));
  endtask

  task automatic basicBlock(input logic [127:0] vec, input logic [127:0] res, input int expLat);
    int seen;
    outReady = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b1;
    inState = vec;
    @(posedge clock); #1;
    inValid = 1'b0;
    waitOutValid(expLat + 8, seen);
    check("latency", 128'(seen - acceptEdge), 128'(expLat));
    @(negedge clock);
    check("outValidPulse", 128'(curOutValid), 128'(0));
    check("outStateHeld", curOutState, res);
    check("inReadyAfter", 128'(curInReady), 128'(1));
  endtask

  initial begin
    int seen;
    logic [127:0] v3, r3, v4;
    v3 = {$urandom, $urandom, $urandom, $urandom};
    r3 = model(v3);
    v4 = {$urandom, $urandom, $urandom, $urandom};

    // Reset state
    repeat (2) @(negedge clock);
    check("rstOutValid", 128'(curOutValid), 128'(0));
    check("rstOutState", curOutState, 128'(0));
    check("rstBusy", 128'(curBusy), 128'(0));
    reset = 1'b1;
    @(negedge clock);
    check("rstInReady", 128'(curInReady), 128'(1));

    // Basic block and known bytes
    basicBlock(V1, R1, 4);
    basicBlock(V2, R2, 4);
    basicBlock(v4, model(v4), 4);

    // Backpressure
    outReady = 1'b0;
    @(posedge clock); #1;
    inValid = 1'b1;
    inState = v3;
    @(posedge clock); #1;
    inState = V1;
    waitOutValid(12, seen);
    for (int i = 0; i < 10; i++) begin
      check("bpOutValid", 128'(curOutValid), 128'(1));
      check("bpOutState", curOutState, r3);
      check("bpInReady", 128'(curInReady), 128'(0));
      @(negedge clock);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clock);
    check("bpReleaseOutValid", 128'(curOutValid), 128'(0));
    check("bpReleaseInReady", 128'(curInReady), 128'(1));
    waitDrain(4);

    // Back-to-back
    @(posedge clock); #1;
    inValid = 1'b1;
    inState = V1;
    @(posedge clock); #1;
    inState = V2;
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (curInReady) begin
        seen = cyc + 1;
        break;
      end
    end
    check("b2bAcceptGap", 128'(seen - hsEdge), 128'(1));
    @(posedge clock); #1;
    inValid = 1'b0;
    waitDrain(20);

    // Reset mid-SUBST
    @(posedge clock); #1;
    inValid = 1'b1;
    inState = V1;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("midRstOutValid", 128'(curOutValid), 128'(0));
    check("midRstBusy", 128'(curBusy), 128'(0));
    check("midRstOutState", curOutState, 128'(0));
    expQ.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("postRstOutValid", 128'(curOutValid), 128'(0));
    end
    basicBlock(V1, R1, 4);

    // Parameter sweep
    sel = 1;
    @(negedge clock);
    basicBlock(V1, R1, 16);
    sel = 2;
    @(negedge clock);
    basicBlock(V1, R1, 1);
    basicBlock(V2, R2, 1);

    waitDrain(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
